m_proc_p4: RTL
==============

Name: m_proc_p4

Overview:
- Parametrised four-stage in-order RV32I-subset core with stages IF, ID, EX and MA/WB.
- Successor to the current two-register-stage core. It adds:
  - synchronous active-low reset;
  - external instruction and data memory ports;
  - EX-operand forwarding, or a full interlock, selected by parameter;
  - register-file write bypass;
  - two-cycle branch flush;
  - cycle and retired-instruction counters.
- Reuses the existing decode, ALU, adder, mux and register-file primitives.

Parameters:
- RESET_PC, 32'h0, PC value loaded on reset.
- FWD, 1, 1 = forward the MA-stage result into EX operands; 0 = stall in ID until the producer reaches MA.
- CNT_W, 32, width of the cycle and instret counters.

Ports:
- w_clk, input, 1, clock; all state updates on posedge.
- w_rst_n, input, 1, reset: synchronous, active-low.
- w_imem_addr, output, 32, fetch address (equals PC).
- w_imem_data, input, 32, instruction at w_imem_addr, combinational return.
- w_dmem_addr, output, 32, MA-stage ALU result.
- w_dmem_we, output, 1, store strobe for the MA stage.
- w_dmem_wdata, output, 32, store data.
- w_dmem_rdata, input, 32, load data, combinational return in the same cycle.
- w_cycle, output, CNT_W, cycles since reset release.
- w_instret, output, CNT_W, retired instructions.

Behaviour:
- Reset (w_rst_n=0 at posedge):
  - PC=RESET_PC.
  - P1/P2/P3 valid bits=0.
  - Counters=0.
  - Register-file contents are not reset; x0 always reads 0.
- w_dmem_we = P3_v & P3_store & w_rst_n, so a store is never issued while reset is asserted.
- Supported instructions: OP, OP-IMM, LW, SW, and the six conditional branches. Any other opcode is a NOP: no RF write, no store, no redirect.
- IF:
  - PC drives w_imem_addr.
  - P1 <= {w_imem_data, PC, valid}.
  - Next PC is PC+4 (predict not-taken).
- ID:
  - Reads rs1/rs2, generates imm and branch target (P1_pc+imm), latches into P2.
  - RF bypass: if MA writes rd≠0 in this cycle and rd equals rs1 or rs2, ID takes the MA write value.
- EX:
  - ALU runs on the P2 operands.
  - Branch resolves here: w_miss = P2_v & P2_branch & taken.
- MA/WB:
  - Memory access uses P3 registers.
  - Write-back value is the load data if the instruction is a load, otherwise the ALU result.
  - RF is written at posedge when P3_v, the instruction writes, and rd≠0.
- Forwarding, FWD=1:
  - An EX operand whose rs equals the P3 rd (P3 writes, rd≠0) takes the MA write-back value, load data included.
  - No data-hazard stalls.
- Interlock, FWD=0:
  - If an ID source (rd≠0) matches the rd of a valid writing instruction in EX, stall.
  - Stall holds PC and P1 and inserts a bubble into P2.
  - Matches against MA are covered by the RF bypass.
- Only sources an instruction actually uses are compared: rs2 only for OP, store and branch.
- Flush on w_miss:
  - PC <= branch target.
  - P1_v and the incoming P2_v are cleared, giving a 2-cycle penalty.
  - Flush overrides any concurrent stall.
- Counters:
  - w_cycle increments every non-reset cycle and wraps at 2^CNT_W.
  - w_instret increments when P3_v=1, covering stores and branches but not bubbles or flushed instructions; it wraps.

Test Plan:
- Reset: hold w_rst_n=0 for 3 cycles with w_imem_data=NOP, then release.
  - w_imem_addr=0 during reset; cycles 0,1,2 after release show 0, 4, 8.
  - w_dmem_we=0 throughout reset.
  - Counters are 0 in cycle 0.
- Forwarding, FWD=1: program is addi x1,x0,5; addi x2,x1,7; sw x2,16(x0).
  - w_dmem_we=1 in cycle 5 with addr=16, wdata=12.
  - w_instret=3 in cycle 6.
- Interlock, FWD=0, same program:
  - Identical store, but in cycle 7 (one bubble per dependency).
  - The fetch address repeats during each stall.
- Load-use, FWD=1: program stores 12 at 16; lw x3,16(x0); add x4,x3,x3; sw x4,20(x0).
  - Expected store is addr=20, wdata=24 with no stall cycles.
- Taken branch: beq x0,x0,+12 at 0x20, with sw placed at 0x24 and 0x28.
  - Neither store issues.
  - Fetch sequence is 0x20, 0x24, 0x28, 0x2C.
  - w_instret counts only the branch and later instructions.
- Reset mid-store: drop w_rst_n while sw x2,16(x0) is in MA.
  - w_dmem_we=0 in that cycle.
  - PC=RESET_PC and w_instret=0 after the edge.

Source files
------------

// File: rtl/m_proc_p4.sv
// m_proc_p4: four-stage in-order RV32I-subset core (IF, ID, EX, MA/WB).
// Handles OP, OP-IMM, LW, SW and the six conditional branches; all other encodings act as NOPs.
// Load data is forwarded straight into EX (FWD=1), or ID stalls behind an EX producer (FWD=0).
module m_proc_p4 #(
    parameter logic [31:0] RESET_PC = 32'h0,
    parameter int unsigned FWD      = 1,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    output logic [31:0]      w_imem_addr,
    input  logic [31:0]      w_imem_data,
    output logic [31:0]      w_dmem_addr,
    output logic             w_dmem_we,
    output logic [31:0]      w_dmem_wdata,
    input  logic [31:0]      w_dmem_rdata,
    output logic [CNT_W-1:0] w_cycle,
    output logic [CNT_W-1:0] w_instret
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam bit         FWD_EN     = (FWD != 0);

    typedef struct packed {
        logic        use1;
        logic        use2;
        logic        wr;
        logic        is_op;
        logic        is_opimm;
        logic        is_load;
        logic        is_store;
        logic        is_br;
        logic [2:0]  f3;
        logic        f7b5;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } dec_t;

    // Instruction decode: class flags, used sources and sign-extended immediate
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d      = '0;
        d.f3   = ins[14:12];
        d.f7b5 = ins[30];
        d.rs1  = ins[19:15];
        d.rs2  = ins[24:20];
        d.rd   = ins[11:7];
        d.imm  = {{20{ins[31]}}, ins[31:20]};
        case (ins[6:0])
            OPC_OP: begin
                d.is_op = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1; d.wr = 1'b1;
            end
            OPC_OPIMM: begin
                d.is_opimm = 1'b1; d.use1 = 1'b1; d.wr = 1'b1;
            end
            OPC_LOAD: begin
                if (ins[14:12] == 3'b010) begin
                    d.is_load = 1'b1; d.use1 = 1'b1; d.wr = 1'b1;
                end
            end
            OPC_STORE: begin
                if (ins[14:12] == 3'b010) begin
                    d.is_store = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
                    d.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
                end
            end
            OPC_BRANCH: begin
                if (ins[14:13] != 2'b01) begin
                    d.is_br = 1'b1; d.use1 = 1'b1; d.use2 = 1'b1;
                    d.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
                end
            end
            default: ;
        endcase
        return d;
    endfunction

    logic [31:0] pc;
    logic        p1_v;
    logic [31:0] p1_instr, p1_pc;
    logic        p2_v;
    dec_t        p2_d;
    logic [31:0] p2_v1, p2_v2, p2_tgt;
    logic        p3_v, p3_wr, p3_load, p3_store;
    logic [4:0]  p3_rd;
    logic [31:0] p3_alu, p3_sdata;
    logic [31:0] rf [32];

    dec_t        id_d;
    logic [31:0] id_v1, id_v2;
    logic [31:0] ex_a, ex_b, alu_b, alu_y;
    logic        taken, miss, stall, wb_en;
    logic [31:0] wb_val;

    assign w_imem_addr  = pc;
    assign w_dmem_addr  = p3_alu;
    assign w_dmem_wdata = p3_sdata;
    assign w_dmem_we    = p3_v & p3_store & w_rst_n;
    assign wb_val       = p3_load ? w_dmem_rdata : p3_alu;
    assign wb_en        = p3_v & p3_wr & (p3_rd != 5'd0);
    assign id_d         = decode(p1_instr);

    // ID register read with bypass of the value being written back this cycle
    always_comb begin
        id_v1 = (id_d.rs1 == 5'd0) ? 32'd0 : rf[id_d.rs1];
        id_v2 = (id_d.rs2 == 5'd0) ? 32'd0 : rf[id_d.rs2];
        if (wb_en && (p3_rd == id_d.rs1)) id_v1 = wb_val;
        if (wb_en && (p3_rd == id_d.rs2)) id_v2 = wb_val;
    end

    // Interlock: hold ID while a valid writing instruction in EX produces a used source
    always_comb begin
        stall = 1'b0;
        if (!FWD_EN && p1_v && p2_v && p2_d.wr && (p2_d.rd != 5'd0)) begin
            stall = (id_d.use1 && (id_d.rs1 == p2_d.rd)) ||
                    (id_d.use2 && (id_d.rs2 == p2_d.rd));
        end
    end

    // EX operands, optionally forwarded from the MA write-back value
    always_comb begin
        ex_a = p2_v1;
        ex_b = p2_v2;
        if (FWD_EN && wb_en && p2_d.use1 && (p3_rd == p2_d.rs1)) ex_a = wb_val;
        if (FWD_EN && wb_en && p2_d.use2 && (p3_rd == p2_d.rs2)) ex_b = wb_val;
        alu_b = p2_d.is_op ? ex_b : p2_d.imm;
    end

    // ALU: full function set for OP/OP-IMM, address add for loads and stores
    always_comb begin
        alu_y = ex_a + alu_b;
        if (p2_d.is_op || p2_d.is_opimm) begin
            case (p2_d.f3)
                3'b000:  alu_y = (p2_d.is_op && p2_d.f7b5) ? ex_a - alu_b : ex_a + alu_b;
                3'b001:  alu_y = ex_a << alu_b[4:0];
                3'b010:  alu_y = {31'd0, $signed(ex_a) < $signed(alu_b)};
                3'b011:  alu_y = {31'd0, ex_a < alu_b};
                3'b100:  alu_y = ex_a ^ alu_b;
                3'b101:  alu_y = p2_d.f7b5 ? 32'($signed(ex_a) >>> alu_b[4:0])
                                           : ex_a >> alu_b[4:0];
                3'b110:  alu_y = ex_a | alu_b;
                default: alu_y = ex_a & alu_b;
            endcase
        end
    end

    // Branch condition and redirect
    always_comb begin
        case (p2_d.f3)
            3'b000:  taken = (ex_a == ex_b);
            3'b001:  taken = (ex_a != ex_b);
            3'b100:  taken = ($signed(ex_a) < $signed(ex_b));
            3'b101:  taken = ($signed(ex_a) >= $signed(ex_b));
            3'b110:  taken = (ex_a < ex_b);
            3'b111:  taken = (ex_a >= ex_b);
            default: taken = 1'b0;
        endcase
        miss = p2_v & p2_d.is_br & taken;
    end

    // Pipeline registers, PC and counters; redirect takes priority over stall
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            pc        <= RESET_PC;
            p1_v      <= 1'b0;
            p2_v      <= 1'b0;
            p3_v      <= 1'b0;
            w_cycle   <= '0;
            w_instret <= '0;
        end else begin
            w_cycle <= w_cycle + CNT_W'(1);
            if (p3_v) w_instret <= w_instret + CNT_W'(1);
            if (miss) begin
                pc   <= p2_tgt;
                p1_v <= 1'b0;
            end else if (!stall) begin
                pc       <= pc + 32'd4;
                p1_v     <= 1'b1;
                p1_instr <= w_imem_data;
                p1_pc    <= pc;
            end
            p2_v     <= p1_v & ~miss & ~stall;
            p2_d     <= id_d;
            p2_v1    <= id_v1;
            p2_v2    <= id_v2;
            p2_tgt   <= p1_pc + id_d.imm;
            p3_v     <= p2_v;
            p3_wr    <= p2_d.wr;
            p3_load  <= p2_d.is_load;
            p3_store <= p2_d.is_store;
            p3_rd    <= p2_d.rd;
            p3_alu   <= alu_y;
            p3_sdata <= ex_b;
        end
    end

    // Register file write-back; x0 is never written
    always_ff @(posedge w_clk) begin
        if (w_rst_n && wb_en) rf[p3_rd] <= wb_val;
    end

endmodule
